// File: rtl/conv_bin_bcd_pkg.sv
// rtl/conv_bin_bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package conv_bin_bcd_pkg;

  localparam int ANCHO_DATO  = 16;
  localparam int NUM_DIGITOS = 5;
  localparam int ANCHO_BCD   = 4 * NUM_DIGITOS;

  // Double-dabble correction: any nibble at or above this value gets +3 before the shift
  localparam logic [3:0] UMBRAL_AJUSTE = 4'd5;
  localparam logic [3:0] SUMA_AJUSTE   = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } estado_t;

endpackage

// File: rtl/conv_bin_bcd_ajuste_bcd.sv
// rtl/conv_bin_bcd_ajuste_bcd.sv - add-3 correction for one BCD digit
module ajuste_bcd
  import conv_bin_bcd_pkg::*;
(
  input  logic [3:0] i_digito,
  output logic [3:0] o_digito
);

  // A digit >= 5 would exceed 9 after the left shift, so pre-add 3 to carry into the next digit
  assign o_digito = (i_digito >= UMBRAL_AJUSTE) ? (i_digito + SUMA_AJUSTE) : i_digito;

endmodule

// File: rtl/conv_bin_bcd.sv
// rtl/conv_bin_bcd.sv - sequential signed binary to sign-magnitude BCD converter
module conv_bin_bcd #(
  parameter int ANCHO_DATO  = conv_bin_bcd_pkg::ANCHO_DATO,
  parameter int NUM_DIGITOS = conv_bin_bcd_pkg::NUM_DIGITOS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [ANCHO_DATO-1:0]    producto,
  output logic                     busy,
  output logic                     done,
  output logic                     signo,
  output logic [4*NUM_DIGITOS-1:0] digitos,
  output logic [NUM_DIGITOS-1:0]   blanco
);

  import conv_bin_bcd_pkg::*;

  localparam int ANCHO_B   = 4 * NUM_DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO_DATO);
  localparam logic [ANCHO_CNT-1:0] ULTIMA_ITER = ANCHO_CNT'(ANCHO_DATO - 1);
  // After reset only the units digit is visible, so all higher digits are blanked
  localparam logic [NUM_DIGITOS-1:0] BLANCO_RESET = {{(NUM_DIGITOS-1){1'b1}}, 1'b0};

  estado_t                r_estado;
  logic [ANCHO_CNT-1:0]   r_cnt;
  logic [ANCHO_DATO-1:0]  r_mag;
  logic [ANCHO_B-1:0]     r_bcd;
  logic                   r_signo_cap;

  logic [ANCHO_DATO-1:0]  w_magnitud;
  logic [ANCHO_B-1:0]     w_bcd_adj;
  logic [ANCHO_B-1:0]     w_bcd_sig;
  logic [ANCHO_DATO-1:0]  w_mag_sig;
  logic [NUM_DIGITOS-1:0] w_blanco;
  logic                   w_ultima;
  logic                   w_no_cero;

  // Two's-complement negate wraps modulo 2^N, so the most negative value maps to its unsigned magnitude
  assign w_magnitud = producto[ANCHO_DATO-1] ? ((~producto) + ANCHO_DATO'(1)) : producto;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
      ajuste_bcd u_ajuste (
        .i_digito (r_bcd[4*g +: 4]),
        .o_digito (w_bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // One double-dabble step: corrected BCD and magnitude shift left together as one long register
  assign w_bcd_sig = {w_bcd_adj[ANCHO_B-2:0], r_mag[ANCHO_DATO-1]};
  assign w_mag_sig = {r_mag[ANCHO_DATO-2:0], 1'b0};
  assign w_ultima  = (r_cnt == ULTIMA_ITER);
  assign w_no_cero = |w_bcd_sig;
  assign busy      = (r_estado == CONV);

  // Leading-zero mask: a digit is blanked when it and every digit above it are zero; units never blank
  always_comb begin
    logic v_cero_sup;
    w_blanco   = '0;
    v_cero_sup = 1'b1;
    for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
      v_cero_sup  = v_cero_sup & (w_bcd_sig[4*i +: 4] == 4'd0);
      w_blanco[i] = v_cero_sup;
    end
  end

  // Control FSM: capture in IDLE, iterate once per bit in CONV, publish results on the final step
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_estado    <= IDLE;
      r_cnt       <= '0;
      r_mag       <= '0;
      r_bcd       <= '0;
      r_signo_cap <= 1'b0;
      done        <= 1'b0;
      signo       <= 1'b0;
      digitos     <= '0;
      blanco      <= BLANCO_RESET;
    end else begin
      done <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (valid) begin
            r_signo_cap <= producto[ANCHO_DATO-1];
            r_mag       <= w_magnitud;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_estado    <= CONV;
          end
        end
        CONV: begin
          r_bcd <= w_bcd_sig;
          r_mag <= w_mag_sig;
          r_cnt <= r_cnt + ANCHO_CNT'(1);
          if (w_ultima) begin
            digitos  <= w_bcd_sig;
            // A zero result is reported as positive even if the input sign bit was set
            signo    <= r_signo_cap & w_no_cero;
            blanco   <= w_blanco;
            done     <= 1'b1;
            r_estado <= IDLE;
          end
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bin_bcd.sv
// tb/tb_conv_bin_bcd.sv - scoreboard bench for conv_bin_bcd
module tb_conv_bin_bcd;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] producto;
  logic        busy;
  logic        done;
  logic        signo;
  logic [19:0] digitos;
  logic [4:0]  blanco;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [19:0] d;
    logic        s;
    logic [4:0]  b;
    int          c;
  } exp_t;

  exp_t sb[$];

  conv_bin_bcd dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .producto (producto),
    .busy     (busy),
    .done     (done),
    .signo    (signo),
    .digitos  (digitos),
    .blanco   (blanco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int p, input int c);
    exp_t e;
    int   mag;
    int   pw;
    mag = (p < 0) ? -p : p;
    pw  = 1;
    e.b = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      e.d[4*k +: 4] = 4'((mag / pw) % 10);
      if (k >= 1) e.b[k] = (mag < pw);
      pw = pw * 10;
    end
    e.s = (p < 0);
    e.c = c;
    return e;
  endfunction

  task automatic start(input int p);
    valid    = 1'b1;
    producto = 16'(p);
    if (!busy && rst) sb.push_back(model(p, cyc + 17));
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_signo"}, signo, 1'b0);
    chk({tag, "_digitos"}, digitos, 20'h0);
    chk({tag, "_blanco"}, blanco, 5'b11110);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("digitos", digitos, e.d);
        chk("signo", signo, e.s);
        chk("blanco", blanco, e.b);
        chk("latency", cyc, e.c);
      end
    end
  end

  initial begin
    int t;
    rst      = 1'b0;
    valid    = 1'b0;
    producto = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);

    start(15);
    chk("busy_conv", busy, 1'b1);
    drain();
    chk("busy_idle", busy, 1'b0);

    start(-32768); drain();
    start(-1);     drain();
    start(0);      drain();
    start(32767);  drain();
    start(-10000); drain();

    // Request while busy must be dropped
    start(123);
    repeat (4) @(negedge clk);
    start(999);
    drain();
    repeat (20) @(negedge clk);

    // Back-to-back: new request in the done cycle
    start(42);
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    start(-7);
    drain();

    // Reset mid-conversion aborts without a done pulse
    start(200);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    start(25);
    drain();

    for (int i = 0; i < 8; i++) begin
      start(int'($urandom_range(0, 65535)) - 32768);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
